// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Shared FSM state encoding, default parameters and RAM address masking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_LS     = 2;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_RAM_AW     = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One bit of the RAM address mask: bits at or above ram_aw are dropped.
    function automatic logic ram_mask_bit(input int bit_idx, input int ram_aw);
        return bit_idx < ram_aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Round-robin one-hot grant; the search starts just past the last winner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_grant;

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        w_grant   = '0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!found && req[idx]) begin
                w_grant[idx] = 1'b1;
                w_ptr_nxt    = IW'((idx + 1) % N);
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && (|req)) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Dual-port RAM front end: port A serves instruction fetch, port B serves
// round-robin arbitrated load/store channels. Rev : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_LS     = DEF_NUM_LS,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int RAM_AW     = DEF_RAM_AW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_valid,
    input  logic [ADDR_WIDTH-1:0]          if_addr,
    output logic                           if_done,
    output logic [DATA_WIDTH-1:0]          if_data,
    input  logic [NUM_LS-1:0]              ls_valid,
    input  logic [NUM_LS-1:0]              ls_we,
    input  logic [NUM_LS*DATA_WIDTH/8-1:0] ls_be,
    input  logic [NUM_LS*ADDR_WIDTH-1:0]   ls_addr,
    input  logic [NUM_LS*DATA_WIDTH-1:0]   ls_src,
    output logic [NUM_LS-1:0]              ls_done,
    output logic [DATA_WIDTH-1:0]          ls_data,
    output logic [ADDR_WIDTH-1:0]          addr_a,
    input  logic [DATA_WIDTH-1:0]          data_a,
    output logic [ADDR_WIDTH-1:0]          addr_b,
    output logic                           we_b,
    output logic [DATA_WIDTH/8-1:0]        be_b,
    output logic [DATA_WIDTH-1:0]          src_b,
    input  logic [DATA_WIDTH-1:0]          data_b
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_LS > 1) ? $clog2(NUM_LS) : 1;

    logic [ADDR_WIDTH-1:0] w_ram_mask;
    logic [NUM_LS-1:0]     w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    state_t                r_a_state;
    logic [2:0]            r_a_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [DATA_WIDTH-1:0] r_if_data;
    logic                  r_if_done;

    state_t                r_b_state;
    logic [2:0]            r_b_cnt;
    logic [NUM_LS-1:0]     r_b_gnt;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic                  r_we_b;
    logic [BE_W-1:0]       r_be_b;
    logic [DATA_WIDTH-1:0] r_src_b;
    logic [DATA_WIDTH-1:0] r_ls_data;
    logic [NUM_LS-1:0]     r_ls_done;

    always_comb begin
        w_ram_mask = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            w_ram_mask[i] = ram_mask_bit(i, RAM_AW);
        end
    end

    rr_arbiter #(
        .N       (NUM_LS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (ls_valid),
        .advance (r_b_state == ST_IDLE),
        .grant   (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_LS; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_addr = ls_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Port A: the address register feeds the RAM, so data is valid RD_LAT
    // cycles into WAIT and is captured on the last WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_state <= ST_IDLE;
            r_a_cnt   <= '0;
            r_addr_a  <= '0;
            r_if_data <= '0;
            r_if_done <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            case (r_a_state)
                ST_IDLE: begin
                    if (if_valid) begin
                        r_addr_a  <= if_addr & w_ram_mask;
                        r_a_cnt   <= '0;
                        r_a_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_a_cnt == 3'(RD_LAT)) begin
                        r_if_data <= data_a;
                        r_if_done <= 1'b1;
                        r_a_state <= ST_DONE;
                    end else begin
                        r_a_cnt <= r_a_cnt + 3'd1;
                    end
                end
                ST_DONE: r_a_state <= ST_IDLE;
                default: r_a_state <= ST_IDLE;
            endcase
        end
    end

    // Port B: RAM samples addr_b during ISSUE, so a read returns RD_LAT
    // cycles later; writes finish straight after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_state <= ST_IDLE;
            r_b_cnt   <= '0;
            r_b_gnt   <= '0;
            r_addr_b  <= '0;
            r_we_b    <= 1'b0;
            r_be_b    <= '0;
            r_src_b   <= '0;
            r_ls_data <= '0;
            r_ls_done <= '0;
        end else begin
            r_we_b    <= 1'b0;
            r_ls_done <= '0;
            case (r_b_state)
                ST_IDLE: begin
                    if (|ls_valid) begin
                        r_b_gnt   <= w_gnt;
                        r_addr_b  <= w_sel_addr & w_ram_mask;
                        r_we_b    <= ls_we[w_gnt_idx];
                        r_be_b    <= ls_be[int'(w_gnt_idx)*BE_W +: BE_W];
                        r_src_b   <= ls_src[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_b_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we_b) begin
                        r_ls_done <= r_b_gnt;
                        r_b_state <= ST_DONE;
                    end else begin
                        r_b_cnt   <= '0;
                        r_b_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_b_cnt == 3'(RD_LAT - 1)) begin
                        r_ls_data <= data_b;
                        r_ls_done <= r_b_gnt;
                        r_b_state <= ST_DONE;
                    end else begin
                        r_b_cnt <= r_b_cnt + 3'd1;
                    end
                end
                ST_DONE: r_b_state <= ST_IDLE;
                default: r_b_state <= ST_IDLE;
            endcase
        end
    end

    assign if_done = r_if_done;
    assign if_data = r_if_data;
    assign addr_a  = r_addr_a;
    assign addr_b  = r_addr_b;
    assign we_b    = r_we_b;
    assign be_b    = r_be_b;
    assign src_b   = r_src_b;
    assign ls_data = r_ls_data;
    assign ls_done = r_ls_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural dual-port RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic [1:0]  ls_valid = '0;
    logic [1:0]  ls_we = '0;
    logic [7:0]  ls_be = '0;
    logic [63:0] ls_addr = '0;
    logic [63:0] ls_src = '0;
    logic [1:0]  ls_done;
    logic [31:0] ls_data;
    logic [31:0] addr_a;
    logic [31:0] data_a = '0;
    logic [31:0] addr_b;
    logic        we_b;
    logic [3:0]  be_b;
    logic [31:0] src_b;
    logic [31:0] data_b = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_LS     (2),
        .RD_LAT     (1),
        .RAM_AW     (18)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_valid (ls_valid),
        .ls_we    (ls_we),
        .ls_be    (ls_be),
        .ls_addr  (ls_addr),
        .ls_src   (ls_src),
        .ls_done  (ls_done),
        .ls_data  (ls_data),
        .addr_a   (addr_a),
        .data_a   (data_a),
        .addr_b   (addr_b),
        .we_b     (we_b),
        .be_b     (be_b),
        .src_b    (src_b),
        .data_b   (data_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] src,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = src[8*k +: 8];
        return r;
    endfunction

    // RAM with one cycle of read latency on both ports
    logic [31:0] ram [0:1023];
    logic        ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        end else begin
            data_a <= ram[addr_a[11:2]];
            data_b <= ram[addr_b[11:2]];
            if (we_b) begin
                for (int k = 0; k < 4; k++)
                    if (be_b[k]) ram[addr_b[11:2]][8*k +: 8] <= src_b[8*k +: 8];
            end
        end
    end

    logic [31:0] ref_mem [0:1023];

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        chk;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        is_ls;
        int          ch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] src;
        logic [31:0] exp_addr;
        int          lat;
    } vec_t;

    exp_t q_if[$];
    exp_t q_ls[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if_done === 1'b1) begin
                if (q_if.size() == 0) begin
                    chk("if_done_unexpected", 64'd1, 64'd0);
                end else begin
                    m_e = q_if.pop_front();
                    chk("if_done_cycle", 64'(m_e.cyc), 64'(cyc));
                    chk("if_data", if_data, m_e.data);
                end
            end
            if (ls_done !== 2'b00) begin
                chk("ls_done_onehot", 64'($onehot(ls_done)), 64'd1);
                if (q_ls.size() == 0) begin
                    chk("ls_done_unexpected", ls_done, 64'd0);
                end else begin
                    m_e = q_ls.pop_front();
                    chk("ls_done_chan", ls_done, 64'(2'b01 << m_e.ch));
                    chk("ls_done_cycle", 64'(cyc), 64'(m_e.cyc));
                    if (m_e.chk) chk("ls_data", ls_data, m_e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while ((q_if.size() != 0 || q_ls.size() != 0) && k < 30);
        if (q_if.size() != 0 || q_ls.size() != 0) begin
            chk("done_timeout", 64'(q_if.size() + q_ls.size()), 64'd0);
            q_if.delete();
            q_ls.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_ls_done"}, ls_done, 0);
        chk({tag, "_we_b"},    we_b, 0);
        chk({tag, "_be_b"},    be_b, 0);
        chk({tag, "_addr_a"},  addr_a, 0);
        chk({tag, "_addr_b"},  addr_b, 0);
        chk({tag, "_src_b"},   src_b, 0);
        chk({tag, "_if_data"}, if_data, 0);
        chk({tag, "_ls_data"}, ls_data, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        exp_t e;
        int   c;
        @(negedge clk);
        if (v.is_ls) begin
            ls_valid[v.ch]          = 1'b1;
            ls_we[v.ch]             = v.we;
            ls_be[v.ch*4 +: 4]      = v.be;
            ls_addr[v.ch*32 +: 32]  = v.addr;
            ls_src[v.ch*32 +: 32]   = v.src;
        end else begin
            if_valid = 1'b1;
            if_addr  = v.addr;
        end
        c     = cyc;
        e.ch  = v.is_ls ? v.ch : -1;
        e.cyc = c + v.lat;
        e.chk = !(v.is_ls && v.we);
        if (v.is_ls && v.we) begin
            ref_mem[v.exp_addr[11:2]] = merge(ref_mem[v.exp_addr[11:2]], v.src, v.be);
            e.data = '0;
        end else begin
            e.data = ref_mem[v.exp_addr[11:2]];
        end
        if (v.is_ls) q_ls.push_back(e);
        else         q_if.push_back(e);
        @(posedge clk); #1;
        ls_valid = '0;
        if_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_addr"}, v.is_ls ? addr_b : addr_a, v.exp_addr);
        if (v.is_ls) chk({nm, "_we_b_issue"}, we_b, v.we);
        if (v.is_ls && v.we) begin
            chk({nm, "_be_b"}, be_b, v.be);
            chk({nm, "_src_b"}, src_b, v.src);
            @(negedge clk);
            chk({nm, "_we_b_after"}, we_b, 0);
        end
        wait_idle();
    endtask

    vec_t vt [9];
    exp_t e0;
    int   c0;

    initial begin
        //          is_ls ch we  be     addr           src            exp_addr       lat
        vt[0] = '{1'b0, 0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h0000_0100, 3};
        vt[1] = '{1'b1, 1, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0200, 2};
        vt[2] = '{1'b1, 0, 1'b0, 4'hF, 32'h0000_0200, 32'h0,         32'h0000_0200, 3};
        vt[3] = '{1'b0, 0, 1'b0, 4'h0, 32'hFFFC_0008, 32'h0,         32'h0000_0008, 3};
        vt[4] = '{1'b1, 0, 1'b1, 4'h5, 32'h0000_0104, 32'h1122_3344, 32'h0000_0104, 2};
        vt[5] = '{1'b0, 0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         32'h0000_0104, 3};
        vt[6] = '{1'b1, 1, 1'b0, 4'hF, 32'h0004_0200, 32'h0,         32'h0000_0200, 3};
        vt[7] = '{1'b1, 1, 1'b1, 4'h8, 32'h0000_0008, 32'hAABB_CCDD, 32'h0000_0008, 2};
        vt[8] = '{1'b1, 0, 1'b0, 4'hF, 32'h0000_0008, 32'h0,         32'h0000_0008, 3};

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        ram_init = 1'b0;
        rst      = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset in the WAIT cycle of a pending read: transaction discarded.
        @(negedge clk);
        ls_valid[0]     = 1'b1;
        ls_we[0]        = 1'b0;
        ls_be[3:0]      = 4'hF;
        ls_addr[31:0]   = 32'h0000_0100;
        @(posedge clk); #1;
        ls_valid = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round robin from a fresh pointer with both channels held.
        @(negedge clk);
        ls_valid       = 2'b11;
        ls_we          = 2'b00;
        ls_be          = 8'hFF;
        ls_addr        = {32'h0000_0200, 32'h0000_0100};
        c0             = cyc;
        e0.chk         = 1'b1;
        e0.ch = 0; e0.data = ref_mem[32'h100 >> 2]; e0.cyc = c0 + 3;  q_ls.push_back(e0);
        e0.ch = 1; e0.data = ref_mem[32'h200 >> 2]; e0.cyc = c0 + 7;  q_ls.push_back(e0);
        e0.ch = 0; e0.data = ref_mem[32'h100 >> 2]; e0.cyc = c0 + 11; q_ls.push_back(e0);
        repeat (9) @(posedge clk);
        #1;
        ls_valid = '0;
        wait_idle();

        // Fetch and load issued together complete in the same cycle.
        @(negedge clk);
        if_valid      = 1'b1;
        if_addr       = 32'h0000_0104;
        ls_valid[0]   = 1'b1;
        ls_we[0]      = 1'b0;
        ls_addr[31:0] = 32'h0000_0008;
        c0            = cyc;
        e0.chk = 1'b1;
        e0.ch = -1; e0.data = ref_mem[32'h104 >> 2]; e0.cyc = c0 + 3; q_if.push_back(e0);
        e0.ch = 0;  e0.data = ref_mem[32'h008 >> 2]; e0.cyc = c0 + 3; q_ls.push_back(e0);
        @(posedge clk); #1;
        if_valid = 1'b0;
        ls_valid = '0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, requester/RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter NUM_LS, default 2, number of load/store channels, 1..8.
REQ-004 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles, 1..4.
REQ-005 SHALL have parameter RAM_AW, default 18, implemented RAM address bits.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have fetch ports: if_valid  in  1  request; if_addr  in  ADDR_WIDTH  address; if_done  out  1  completion pulse; if_data  out  DATA_WIDTH  read data.
REQ-008 SHALL have load/store ports: ls_valid  in  NUM_LS  request; ls_we  in  NUM_LS  write; ls_be  in  NUM_LS*DATA_WIDTH/8  byte enables; ls_addr  in  NUM_LS*ADDR_WIDTH  address; ls_src  in  NUM_LS*DATA_WIDTH  write data; ls_done  out  NUM_LS  one-hot completion pulse; ls_data  out  DATA_WIDTH  read data.
REQ-009 SHALL have RAM ports: addr_a  out  ADDR_WIDTH; data_a  in  DATA_WIDTH; addr_b  out  ADDR_WIDTH; we_b  out  1; be_b  out  DATA_WIDTH/8; src_b  out  DATA_WIDTH; data_b  in  DATA_WIDTH.

Function
REQ-010 Port A (fetch) SHALL run FSM IDLE -> WAIT -> DONE -> IDLE; port B (load/store) SHALL run FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with writes skipping WAIT.
REQ-011 Both FSMs SHALL operate independently and concurrently.
REQ-012 In IDLE, if_valid high SHALL register addr_a <= if_addr with bits above RAM_AW zeroed; FSM -> WAIT.
REQ-013 Port A WAIT SHALL last RD_LAT+1 cycles, then capture data_a into if_data and assert if_done for exactly one cycle (DONE).
REQ-014 Fetch latency SHALL be RD_LAT+2 cycles from the cycle if_valid is sampled to the if_done cycle.
REQ-015 if_data SHALL hold its value until the next fetch completes.
REQ-016 In port B IDLE, a round-robin arbiter SHALL grant the first asserted ls_valid at or after the index following the last granted channel, starting from 0 after reset.
REQ-017 ISSUE SHALL drive addr_b (masked as in REQ-012), we_b, be_b, src_b from the granted channel; we_b SHALL be high for exactly the one ISSUE cycle, otherwise 0.
REQ-018 A write SHALL pulse ls_done[grant] in the cycle after ISSUE.
REQ-019 A read SHALL wait RD_LAT cycles after ISSUE, capture data_b into ls_data, and pulse ls_done[grant] in the following cycle; ls_data SHALL hold until the next read completes.
REQ-020 ls_valid/if_valid SHALL NOT be sampled in DONE; a requester holding valid across done SHALL get a new transaction.
REQ-021 A transaction SHALL complete and pulse done even if valid drops after sampling; there SHALL be no abort.
REQ-022 Same-address port A read and port B write SHALL NOT be forwarded; port A returns whatever the RAM returns.
REQ-023 At most one ls_done bit SHALL be high in any cycle.

Reset
REQ-024 rst high SHALL asynchronously clear if_done, ls_done, we_b, be_b, addr_a, addr_b, src_b, if_data and ls_data to 0.
REQ-025 rst high SHALL asynchronously force both FSMs to IDLE and the round-robin pointer to 0.
REQ-026 Reset mid-transaction SHALL discard the transaction with no done pulse; first sampling SHALL occur on the first clk edge after rst deasserts.

Structure
REQ-027 Package mem_pkg SHALL hold the FSM state enum, default parameter constants and a RAM address-mask function.
REQ-028 Round-robin grant logic SHALL be sub-module rr_arbiter (parameter N, inputs req/advance, output one-hot grant).

Verification (NUM_LS=2, RD_LAT=1, RAM_AW=18)
REQ-029 Fetch: if_valid in cycle 0 with if_addr=0x0000_0100 -> addr_a=0x100 from cycle 1; if_done high only in cycle 3; if_data=mem[0x100].
REQ-030 Write: ch1 ls_we=1, ls_be=0xF, addr 0x200, src 0xDEADBEEF in cycle 0 -> we_b high only in cycle 1 with addr_b=0x200; ls_done=2'b10 in cycle 2.
REQ-031 Round-robin: both channels request reads continuously -> grants alternate ch0, ch1, ch0; each done is 4 cycles apart; done is never both high.
REQ-032 Mask: if_addr=0xFFFC_0008 -> addr_a=0x0000_0008.
REQ-033 Concurrency: fetch and ch0 read issued in the same cycle -> both done in cycle 3; if_data and ls_data each match RAM contents.
REQ-034 Reset: rst pulsed in cycle 2 of a pending read -> all outputs 0 immediately; no ls_done; a new request after release completes normally.
